// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and VGA timing for the scanout and Display blocks.
// Default timing is 640x480@60; the cell index helper maps (row, col) to a framebuffer bit.
package fb_pkg;

  localparam int FB_W    = 40;
  localparam int FB_H    = 30;
  localparam int FB_BITS = FB_W * FB_H;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int CNT_W = 10;

  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic [5:0] col;
    logic [4:0] row;
    logic       act;
    logic       hs;
    logic       vs;
  } s1_t;

  // row*40 + col built from shifts so no multiplier is inferred
  function automatic logic [10:0] cell_index(input logic [5:0] col, input logic [4:0] row);
    return ({6'b0, row} << 5) + ({6'b0, row} << 3) + {5'b0, col};
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Framebuffer input and VGA output bundle of the scanout block.
// The slave side is the scanout itself; the master side is its environment.
interface fb_scanout_if;
  import fb_pkg::*;

  logic [FB_BITS-1:0] framebuffer;
  logic [3:0]         vga_r;
  logic [3:0]         vga_g;
  logic [3:0]         vga_b;
  logic               vga_hs;
  logic               vga_vs;
  logic               frame_start;

  modport master (
    output framebuffer,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
  );

  modport slave (
    input  framebuffer,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
  );

endinterface

// File: rtl/fb_scanout_vga_timing.sv
// Pixel-rate divider plus horizontal/vertical counters for VGA timing.
// Sync, active and frame_tick outputs are decoded combinationally from the raw counts.
module vga_timing #(
  parameter int PIX_DIV = 2,
  parameter int H_VIS   = fb_pkg::H_VIS,
  parameter int H_FP    = fb_pkg::H_FP,
  parameter int H_SYNC  = fb_pkg::H_SYNC,
  parameter int H_BP    = fb_pkg::H_BP,
  parameter int V_VIS   = fb_pkg::V_VIS,
  parameter int V_FP    = fb_pkg::V_FP,
  parameter int V_SYNC  = fb_pkg::V_SYNC,
  parameter int V_BP    = fb_pkg::V_BP
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic                     pix_en_o,
  output logic                     frame_tick_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic                     active_o,
  output logic [fb_pkg::CNT_W-1:0] hcnt_o,
  output logic [fb_pkg::CNT_W-1:0] vcnt_o
);
  import fb_pkg::*;

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             pix_en;

  // With PIX_DIV=1 the divider sits at 0 and pix_en is permanently high
  assign pix_en = (div_q == DIV_LAST);

  always_comb begin
    div_d  = pix_en ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign pix_en_o     = pix_en;
  assign hcnt_o       = hcnt_q;
  assign vcnt_o       = vcnt_q;
  assign hs_o         = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
  assign vs_o         = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
  assign active_o     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign frame_tick_o = pix_en && (hcnt_q == '0) && (vcnt_q == V_ACT);

endmodule

// File: rtl/fb_scanout.sv
// VGA scanout of the 40x30 monochrome framebuffer, snapshotted once per frame at vblank.
// A two-stage pixel pipeline keeps colour and sync aligned at the connector.
module fb_scanout #(
  parameter int          PIX_DIV    = 2,
  parameter int          CELL_SHIFT = 4,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter int          H_VIS      = fb_pkg::H_VIS,
  parameter int          H_FP       = fb_pkg::H_FP,
  parameter int          H_SYNC     = fb_pkg::H_SYNC,
  parameter int          H_BP       = fb_pkg::H_BP,
  parameter int          V_VIS      = fb_pkg::V_VIS,
  parameter int          V_FP       = fb_pkg::V_FP,
  parameter int          V_SYNC     = fb_pkg::V_SYNC,
  parameter int          V_BP       = fb_pkg::V_BP
) (
  input  logic         clock,
  input  logic         reset_n,
  fb_scanout_if.slave  fb_if
);
  import fb_pkg::*;

  localparam s1_t S1_RESET = '{col: '0, row: '0, act: 1'b0, hs: 1'b1, vs: 1'b1};

  logic               pix_en, frame_tick, hs_raw, vs_raw, act_raw;
  logic [CNT_W-1:0]   hcnt, vcnt;
  s1_t                s1_q, s1_d;
  logic [FB_BITS-1:0] snap_q;
  rgb_t               rgb_q, rgb_d;
  logic               hs_q, vs_q, frame_start_q;
  logic [10:0]        idx;
  logic               px_bit;

  vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clock        (clock),
    .reset_n      (reset_n),
    .pix_en_o     (pix_en),
    .frame_tick_o (frame_tick),
    .hs_o         (hs_raw),
    .vs_o         (vs_raw),
    .active_o     (act_raw),
    .hcnt_o       (hcnt),
    .vcnt_o       (vcnt)
  );

  always_comb begin
    s1_d     = S1_RESET;
    s1_d.col = 6'(hcnt >> CELL_SHIFT);
    s1_d.row = 5'(vcnt >> CELL_SHIFT);
    s1_d.act = act_raw;
    s1_d.hs  = hs_raw;
    s1_d.vs  = vs_raw;
  end

  // Blanked pixels index bit 0 so col/row never address past the framebuffer
  assign idx    = s1_q.act ? cell_index(s1_q.col, s1_q.row) : '0;
  assign px_bit = snap_q[idx];
  assign rgb_d  = s1_q.act ? (px_bit ? FG_COLOR : BG_COLOR) : 12'h000;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap_q        <= '0;
      frame_start_q <= 1'b0;
      s1_q          <= S1_RESET;
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      frame_start_q <= frame_tick;
      if (frame_tick) begin
        snap_q <= fb_if.framebuffer;
      end
      if (pix_en) begin
        s1_q  <= s1_d;
        rgb_q <= rgb_d;
        hs_q  <= s1_q.hs;
        vs_q  <= s1_q.vs;
      end
    end
  end

  assign fb_if.vga_r       = rgb_q[11:8];
  assign fb_if.vga_g       = rgb_q[7:4];
  assign fb_if.vga_b       = rgb_q[3:0];
  assign fb_if.vga_hs      = hs_q;
  assign fb_if.vga_vs      = vs_q;
  assign fb_if.frame_start = frame_start_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout: a reduced-timing instance checked pixel by pixel against a
// frame-level model, plus a full-size 640x480 instance checked for reset and hsync timing.
module tb_fb_scanout;
  import fb_pkg::*;

  localparam int T_DIV    = 2;
  localparam int T_SHIFT  = 1;
  localparam int T_HVIS   = 80;
  localparam int T_HFP    = 2;
  localparam int T_HSYNC  = 4;
  localparam int T_HBP    = 2;
  localparam int T_VVIS   = 60;
  localparam int T_VFP    = 2;
  localparam int T_VSYNC  = 2;
  localparam int T_VBP    = 2;
  localparam int H_TOT    = T_HVIS + T_HFP + T_HSYNC + T_HBP;
  localparam int V_TOT    = T_VVIS + T_VFP + T_VSYNC + T_VBP;
  localparam int FRAME    = H_TOT * V_TOT;
  localparam int SNAP_POS = T_VVIS * H_TOT;
  localparam logic [11:0] T_FG = 12'hEDB;
  localparam logic [11:0] T_BG = 12'h124;
  localparam int FAIL_LIMIT = 200;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  logic clock;
  logic resetN;
  logic [FB_BITS-1:0] fbModel;
  logic [FB_BITS-1:0] modelSnap;
  longint clkCount;
  longint tickCount;
  exp_t   expQ[$];
  exp_t   lastExp;
  int     checks;
  int     failures;
  int     fsCount;

  fb_scanout_if smallIf();
  fb_scanout_if fullIf();

  assign smallIf.framebuffer = fbModel;
  assign fullIf.framebuffer  = '1;

  fb_scanout #(
    .PIX_DIV    (T_DIV),
    .CELL_SHIFT (T_SHIFT),
    .FG_COLOR   (T_FG),
    .BG_COLOR   (T_BG),
    .H_VIS      (T_HVIS),
    .H_FP       (T_HFP),
    .H_SYNC     (T_HSYNC),
    .H_BP       (T_HBP),
    .V_VIS      (T_VVIS),
    .V_FP       (T_VFP),
    .V_SYNC     (T_VSYNC),
    .V_BP       (T_VBP)
  ) dutSmall (
    .clock   (clock),
    .reset_n (resetN),
    .fb_if   (smallIf)
  );

  fb_scanout dutFull (
    .clock   (clock),
    .reset_n (resetN),
    .fb_if   (fullIf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [FB_BITS-1:0] onlyBit(input int b);
    logic [FB_BITS-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [FB_BITS-1:0] randomFb();
    logic [FB_BITS-1:0] v;
    for (int i = 0; i < FB_BITS; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // What the screen shows at raster position q, given the snapshot currently on display
  function automatic exp_t pixelAt(input longint q);
    exp_t e;
    int h, v, idx;
    h = int'(q % H_TOT);
    v = int'((q / H_TOT) % V_TOT);
    e.hs = !(h >= T_HVIS + T_HFP && h < T_HVIS + T_HFP + T_HSYNC);
    e.vs = !(v >= T_VVIS + T_VFP && v < T_VVIS + T_VFP + T_VSYNC);
    e.fs = 1'b0;
    if (h < T_HVIS && v < T_VVIS) begin
      idx   = (v / (1 << T_SHIFT)) * FB_W + (h / (1 << T_SHIFT));
      e.rgb = modelSnap[idx] ? T_FG : T_BG;
    end else begin
      e.rgb = 12'h000;
    end
    return e;
  endfunction

  // Reference producer: one expectation per clock, outputs lag the raster by two pixel ticks
  initial begin
    exp_t e;
    logic fsNow;
    clkCount  = 0;
    tickCount = 0;
    modelSnap = '0;
    lastExp   = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
    forever begin
      @(posedge clock or negedge resetN);
      if (!resetN) begin
        clkCount  = 0;
        tickCount = 0;
        modelSnap = '0;
        expQ.delete();
        lastExp   = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0};
      end else begin
        clkCount++;
        fsNow = 1'b0;
        if (clkCount % T_DIV == 0) begin
          tickCount++;
          if (tickCount >= 2) lastExp = pixelAt(tickCount - 2);
          if ((tickCount - 1) % FRAME == SNAP_POS) begin
            modelSnap = fbModel;
            fsNow     = 1'b1;
          end
        end
        e    = lastExp;
        e.fs = fsNow;
        expQ.push_back(e);
      end
    end
  end

  // Monitor: pops one expectation per clock and compares on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (failures >= FAIL_LIMIT) continue;
      if (!resetN) begin
        checkOutput("inResetRgb", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b}, 12'h000);
        checkOutput("inResetHs", smallIf.vga_hs, 1'b1);
        checkOutput("inResetVs", smallIf.vga_vs, 1'b1);
        checkOutput("inResetFs", smallIf.frame_start, 1'b0);
      end else if (expQ.size() == 0) begin
        checkOutput("scoreboardEmpty", 32'd0, 32'd1);
      end else begin
        e = expQ.pop_front();
        if (smallIf.frame_start === 1'b1) fsCount++;
        checkOutput("pixelRgb", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b}, e.rgb);
        checkOutput("pixelHs", smallIf.vga_hs, e.hs);
        checkOutput("pixelVs", smallIf.vga_vs, e.vs);
        checkOutput("frameStart", smallIf.frame_start, e.fs);
      end
    end
  end

  // Full-size instance: first hsync, hsync width and period; snapshot is empty so rgb stays 0
  initial begin
    int n, lowW, highW, rgbBad, vsBad, fsBad;
    n = 0; lowW = 0; highW = 0; rgbBad = 0; vsBad = 0; fsBad = 0;
    @(posedge resetN);
    do begin
      @(negedge clock);
      n++;
      if ({fullIf.vga_r, fullIf.vga_g, fullIf.vga_b} !== 12'h000) rgbBad++;
      if (fullIf.vga_vs !== 1'b1) vsBad++;
      if (fullIf.frame_start !== 1'b0) fsBad++;
    end while (fullIf.vga_hs !== 1'b0 && n < 5000);
    checkOutput("fullFirstHsLow", n, (656 + 2) * 2);
    do begin
      @(negedge clock);
      lowW++;
      if ({fullIf.vga_r, fullIf.vga_g, fullIf.vga_b} !== 12'h000) rgbBad++;
    end while (fullIf.vga_hs === 1'b0 && lowW < 5000);
    checkOutput("fullHsLowWidth", lowW, 96 * 2);
    do begin
      @(negedge clock);
      highW++;
      if ({fullIf.vga_r, fullIf.vga_g, fullIf.vga_b} !== 12'h000) rgbBad++;
      if (fullIf.vga_vs !== 1'b1) vsBad++;
      if (fullIf.frame_start !== 1'b0) fsBad++;
    end while (fullIf.vga_hs !== 1'b0 && highW < 5000);
    checkOutput("fullHsPeriod", lowW + highW, 800 * 2);
    checkOutput("fullFirstFrameBg", rgbBad, 0);
    checkOutput("fullVsHigh", vsBad, 0);
    checkOutput("fullNoFrameStart", fsBad, 0);
  end

  task automatic applyStimulus(input longint target, input logic [FB_BITS-1:0] newFb);
    int guard;
    guard = 0;
    while (tickCount < target && guard < 400000 && failures < FAIL_LIMIT) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 400000) checkOutput("waitTimeout", guard, 0);
    fbModel = newFb;
  endtask

  initial begin
    int line, col;
    checks   = 0;
    failures = 0;
    fsCount  = 0;
    resetN   = 1'b0;
    fbModel  = onlyBit(0);
    repeat (5) @(posedge clock);
    #1;
    checkOutput("resetRgb", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b}, 12'h000);
    checkOutput("resetHs", smallIf.vga_hs, 1'b1);
    checkOutput("resetVs", smallIf.vga_vs, 1'b1);
    checkOutput("resetFs", smallIf.frame_start, 1'b0);
    @(negedge clock);
    #1 resetN = 1'b1;

    // Frame 0 is blank; frame 1 shows bit 0; change mid-frame-1 must not tear
    line = $urandom_range(5, 50);
    col  = $urandom_range(0, H_TOT - 1);
    applyStimulus(longint'(FRAME + line * H_TOT + col), onlyBit(FB_BITS - 1));
    line = $urandom_range(5, 50);
    col  = $urandom_range(0, H_TOT - 1);
    applyStimulus(longint'(2 * FRAME + line * H_TOT + col), '1);
    applyStimulus(longint'(3 * FRAME + 2 * H_TOT), randomFb());

    // Async reset in the middle of an all-ones frame
    line = $urandom_range(5, 50);
    col  = $urandom_range(10, 60);
    applyStimulus(longint'(3 * FRAME + line * H_TOT + col), fbModel);
    @(posedge clock);
    #2 resetN = 1'b0;
    #1;
    checkOutput("asyncRstRgb", {smallIf.vga_r, smallIf.vga_g, smallIf.vga_b}, 12'h000);
    checkOutput("asyncRstHs", smallIf.vga_hs, 1'b1);
    checkOutput("asyncRstVs", smallIf.vga_vs, 1'b1);
    checkOutput("asyncRstFs", smallIf.frame_start, 1'b0);
    repeat (3) @(negedge clock);
    #1 resetN = 1'b1;

    // Cleared snapshot: blank frame, then the random image from the next frame on
    applyStimulus(longint'(FRAME + 12 * H_TOT), randomFb());
    repeat (4) @(negedge clock);
    checkOutput("frameStartCount", fsCount, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
